// File: rtl/jtkcpu_regfile_if.sv
// Bus bundle between the JTKCPU control/ALU side (master) and the register file (slave).
interface jtkcpu_regfile_if;
  logic [3:0]  rd0_sel, rd1_sel;
  logic [15:0] opnd0, opnd1;
  logic [3:0]  wr_sel;
  logic        wr_we;
  logic [15:0] rslt;
  logic [4:0]  flag_we;
  logic        c_in, v_in, z_in, n_in, h_in;
  logic        cc_ld;
  logic        xfr_we, xfr_exg;
  logic [3:0]  xfr_src, xfr_dst;
  logic        idx_we;
  logic [1:0]  idx_sel;
  logic [2:0]  idx_delta;
  logic        int_ent, int_fast;
  logic        set_e, e_val;
  logic [7:0]  a, b, dp, cc;
  logic [15:0] x, y, u, s;
  logic        nmi_arm;

  modport master (
    output rd0_sel, rd1_sel, wr_sel, wr_we, rslt, flag_we,
           c_in, v_in, z_in, n_in, h_in, cc_ld,
           xfr_we, xfr_exg, xfr_src, xfr_dst,
           idx_we, idx_sel, idx_delta, int_ent, int_fast, set_e, e_val,
    input  opnd0, opnd1, a, b, dp, cc, x, y, u, s, nmi_arm
  );

  modport slave (
    input  rd0_sel, rd1_sel, wr_sel, wr_we, rslt, flag_we,
           c_in, v_in, z_in, n_in, h_in, cc_ld,
           xfr_we, xfr_exg, xfr_src, xfr_dst,
           idx_we, idx_sel, idx_delta, int_ent, int_fast, set_e, e_val,
    output opnd0, opnd1, a, b, dp, cc, x, y, u, s, nmi_arm
  );
endinterface

// File: rtl/jtkcpu_regfile.sv
// JTKCPU programmer-visible registers and CC: ALU writeback, flags, TFR/EXG,
// index adjust, interrupt mask setting and NMI arming.
module jtkcpu_regfile #(
  parameter logic [7:0] RST_CC = 8'h50
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cen,
  jtkcpu_regfile_if.slave   bus
);

  typedef struct packed {
    logic [7:0]  a, b, dp, cc;
    logic [15:0] x, y, u, s;
  } regs_t;

  regs_t regs_q, regs_d;
  logic  nmi_q, nmi_d;

  function automatic logic is8(input logic [3:0] code);
    return code[3:2] == 2'b10;
  endfunction

  function automatic logic [15:0] rd(input regs_t r, input logic [3:0] code);
    case (code)
      4'h0:    return {r.a, r.b};
      4'h1:    return r.x;
      4'h2:    return r.y;
      4'h3:    return r.u;
      4'h4:    return r.s;
      4'h8:    return {8'h00, r.a};
      4'h9:    return {8'h00, r.b};
      4'hA:    return {8'h00, r.cc};
      4'hB:    return {8'h00, r.dp};
      default: return 16'h0000;
    endcase
  endfunction

  // 8-bit sources landing in 16-bit registers are padded with FF; 8-bit targets keep the low byte
  function automatic logic [15:0] conv(input logic [15:0] v, input logic [3:0] src,
                                       input logic [3:0] dst);
    if (is8(src) && !is8(dst)) return {8'hFF, v[7:0]};
    return v;
  endfunction

  function automatic regs_t put(input regs_t r, input logic [3:0] code, input logic [15:0] v);
    regs_t n;
    n = r;
    case (code)
      4'h0: begin n.a = v[15:8]; n.b = v[7:0]; end
      4'h1: n.x  = v;
      4'h2: n.y  = v;
      4'h3: n.u  = v;
      4'h4: n.s  = v;
      4'h8: n.a  = v[7:0];
      4'h9: n.b  = v[7:0];
      4'hA: n.cc = v[7:0];
      4'hB: n.dp = v[7:0];
      default: ;
    endcase
    return n;
  endfunction

  logic [15:0] idx_cur, idx_sum, xfr_sv, xfr_dv;
  logic        s_wr;

  always_comb begin
    case (bus.idx_sel)
      2'd0:    idx_cur = regs_q.x;
      2'd1:    idx_cur = regs_q.y;
      2'd2:    idx_cur = regs_q.u;
      default: idx_cur = regs_q.s;
    endcase
    idx_sum = idx_cur + {{13{bus.idx_delta[2]}}, bus.idx_delta};
    xfr_sv  = rd(regs_q, bus.xfr_src);
    xfr_dv  = rd(regs_q, bus.xfr_dst);
  end

  // Applied lowest priority first so later writes override: flags/idx < wr < xfr < cc_ld
  always_comb begin
    regs_d = regs_q;
    if (bus.flag_we[0]) regs_d.cc[0] = bus.c_in;
    if (bus.flag_we[1]) regs_d.cc[1] = bus.v_in;
    if (bus.flag_we[2]) regs_d.cc[2] = bus.z_in;
    if (bus.flag_we[3]) regs_d.cc[3] = bus.n_in;
    if (bus.flag_we[4]) regs_d.cc[5] = bus.h_in;
    if (bus.idx_we) begin
      case (bus.idx_sel)
        2'd0:    regs_d.x = idx_sum;
        2'd1:    regs_d.y = idx_sum;
        2'd2:    regs_d.u = idx_sum;
        default: regs_d.s = idx_sum;
      endcase
    end
    if (bus.wr_we) regs_d = put(regs_d, bus.wr_sel, bus.rslt);
    if (bus.xfr_we) begin
      if (bus.xfr_exg)
        regs_d = put(regs_d, bus.xfr_src, conv(xfr_dv, bus.xfr_dst, bus.xfr_src));
      regs_d = put(regs_d, bus.xfr_dst, conv(xfr_sv, bus.xfr_src, bus.xfr_dst));
    end
    if (bus.cc_ld) regs_d.cc = bus.rslt[7:0];
    if (bus.set_e) regs_d.cc[7] = bus.e_val;
    regs_d.cc[4] = regs_d.cc[4] | bus.int_ent;
    regs_d.cc[6] = regs_d.cc[6] | (bus.int_ent & bus.int_fast);
  end

  always_comb begin
    s_wr = (bus.idx_we && bus.idx_sel == 2'd3) ||
           (bus.wr_we && bus.wr_sel == 4'h4) ||
           (bus.xfr_we && (bus.xfr_dst == 4'h4 || (bus.xfr_exg && bus.xfr_src == 4'h4)));
    nmi_d = nmi_q | s_wr;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs_q <= '{a: 8'h00, b: 8'h00, dp: 8'h00, cc: RST_CC,
                  x: 16'h0000, y: 16'h0000, u: 16'h0000, s: 16'h0000};
      nmi_q  <= 1'b0;
    end else if (cen) begin
      regs_q <= regs_d;
      nmi_q  <= nmi_d;
    end
  end

  assign bus.opnd0   = rd(regs_q, bus.rd0_sel);
  assign bus.opnd1   = rd(regs_q, bus.rd1_sel);
  assign bus.a       = regs_q.a;
  assign bus.b       = regs_q.b;
  assign bus.dp      = regs_q.dp;
  assign bus.cc      = regs_q.cc;
  assign bus.x       = regs_q.x;
  assign bus.y       = regs_q.y;
  assign bus.u       = regs_q.u;
  assign bus.s       = regs_q.s;
  assign bus.nmi_arm = nmi_q;

endmodule

// File: tb/tb_jtkcpu_regfile.sv
// Directed bench for jtkcpu_regfile with hand-computed expectations.
module tb_jtkcpu_regfile;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cen = 1'b1;
  int   total = 0;
  int   bad = 0;

  jtkcpu_regfile_if bus ();
  jtkcpu_regfile #(.RST_CC(8'h50)) dut (.clk(clk), .rst_n(rst_n), .cen(cen), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.wr_we = 0; bus.wr_sel = 0; bus.rslt = 0; bus.flag_we = 0;
    bus.c_in = 0; bus.v_in = 0; bus.z_in = 0; bus.n_in = 0; bus.h_in = 0;
    bus.cc_ld = 0; bus.xfr_we = 0; bus.xfr_exg = 0; bus.xfr_src = 0; bus.xfr_dst = 0;
    bus.idx_we = 0; bus.idx_sel = 0; bus.idx_delta = 0;
    bus.int_ent = 0; bus.int_fast = 0; bus.set_e = 0; bus.e_val = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] sel, input logic [15:0] v);
    idle();
    bus.wr_we = 1; bus.wr_sel = sel; bus.rslt = v;
    tick();
    idle();
  endtask

  initial begin
    idle();
    bus.rd0_sel = 0; bus.rd1_sel = 0;
    tick(); tick();
    rst_n = 1;
    chk("rst_a", bus.a, 16'h00);
    chk("rst_b", bus.b, 16'h00);
    chk("rst_cc", bus.cc, 16'h50);
    chk("rst_x", bus.x, 16'h0000);
    chk("rst_s", bus.s, 16'h0000);
    chk("rst_nmi", bus.nmi_arm, 16'h0);

    wr(4'h0, 16'h1234);
    chk("wr_d_a", bus.a, 16'h12);
    chk("wr_d_b", bus.b, 16'h34);
    bus.rd0_sel = 4'h0; bus.rd1_sel = 4'h8; #1;
    chk("rd_d", bus.opnd0, 16'h1234);
    chk("rd_a_zext", bus.opnd1, 16'h0012);

    bus.flag_we = 5'b01100; bus.n_in = 1; bus.z_in = 0;
    tick(); idle();
    chk("flags_nz", bus.cc, 16'h58);

    wr(4'h8, 16'h0080);
    bus.xfr_we = 1; bus.xfr_src = 4'h8; bus.xfr_dst = 4'h1;
    tick(); idle();
    chk("tfr_a_x", bus.x, 16'hFF80);
    chk("tfr_a_kept", bus.a, 16'h80);

    wr(4'h1, 16'h1234);
    wr(4'h9, 16'h0056);
    bus.xfr_we = 1; bus.xfr_exg = 1; bus.xfr_src = 4'h1; bus.xfr_dst = 4'h9;
    tick(); idle();
    chk("exg_b", bus.b, 16'h34);
    chk("exg_x", bus.x, 16'hFF56);

    bus.xfr_we = 1; bus.xfr_exg = 1; bus.xfr_src = 4'h1; bus.xfr_dst = 4'h1;
    tick(); idle();
    chk("exg_self", bus.x, 16'hFF56);

    wr(4'h1, 16'hFFFF);
    chk("nmi_before_s", bus.nmi_arm, 16'h0);
    bus.idx_we = 1; bus.idx_sel = 2'd0; bus.idx_delta = 3'b001;
    tick(); idle();
    chk("idx_x_wrap", bus.x, 16'h0000);
    bus.idx_we = 1; bus.idx_sel = 2'd3; bus.idx_delta = 3'b110;
    tick(); idle();
    chk("idx_s_wrap", bus.s, 16'hFFFE);
    chk("nmi_armed", bus.nmi_arm, 16'h1);

    wr(4'h2, 16'h0010);
    bus.wr_we = 1; bus.wr_sel = 4'h2; bus.rslt = 16'h0100;
    bus.idx_we = 1; bus.idx_sel = 2'd1; bus.idx_delta = 3'b010;
    tick(); idle();
    chk("wr_over_idx", bus.y, 16'h0100);

    bus.cc_ld = 1; bus.rslt = 16'h0000; bus.int_ent = 1;
    tick(); idle();
    chk("ccld_int", bus.cc, 16'h10);
    bus.cc_ld = 1; bus.rslt = 16'h0000; bus.int_ent = 1; bus.int_fast = 1;
    tick(); idle();
    chk("ccld_firq", bus.cc, 16'h50);

    bus.set_e = 1; bus.e_val = 1; bus.flag_we = 5'b00001; bus.c_in = 1;
    tick(); idle();
    chk("set_e_c", bus.cc, 16'hD1);

    cen = 0;
    bus.wr_we = 1; bus.wr_sel = 4'h8; bus.rslt = 16'h00AA;
    bus.xfr_we = 1; bus.xfr_src = 4'h1; bus.xfr_dst = 4'h2;
    bus.idx_we = 1; bus.idx_sel = 2'd2; bus.idx_delta = 3'b001;
    bus.int_ent = 1; bus.cc_ld = 1;
    tick(); tick();
    chk("cen0_a", bus.a, 16'h80);
    chk("cen0_y", bus.y, 16'h0100);
    chk("cen0_u", bus.u, 16'h0000);
    chk("cen0_cc", bus.cc, 16'hD1);
    cen = 1;
    tick(); idle();
    chk("cen1_a", bus.a, 16'hAA);
    chk("cen1_y_xfr", bus.y, 16'h0000);
    chk("cen1_u", bus.u, 16'h0001);
    chk("cen1_cc", bus.cc, 16'hBA);

    wr(4'h5, 16'hFFFF);
    bus.rd0_sel = 4'h5; #1;
    chk("bad_code_rd", bus.opnd0, 16'h0000);
    chk("bad_code_a", bus.a, 16'hAA);
    chk("bad_code_x", bus.x, 16'h0000);

    bus.wr_we = 1; bus.wr_sel = 4'h8; bus.rslt = 16'h0033;
    @(posedge clk); #3;
    rst_n = 0; #1;
    chk("arst_a", bus.a, 16'h00);
    chk("arst_u", bus.u, 16'h0000);
    chk("arst_s", bus.s, 16'h0000);
    chk("arst_cc", bus.cc, 16'h50);
    chk("arst_nmi", bus.nmi_arm, 16'h0);
    tick();
    chk("arst_held", bus.a, 16'h00);
    rst_n = 1;
    tick(); idle();
    chk("first_wr", bus.a, 16'h33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
